rv32i_ctrl_alu: RTL and testbench
=================================

// Module: rv32i_ctrl_alu
// PURPOSE
//  Single-cycle RV32I control slice: main decoder, ALU-op decoder and ALU in one block.
//  Sits between instruction fetch and the register file, data memory and PC logic.
//  Everything is combinational except a sticky halt flag raised by "ecall with a7==10".
// PARAMETERS
//  XLEN  32  datapath width (fixed at 32; parameter is for readability only)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset; clears is_halted
//  instr        in   32  current instruction
//  alu_in_1     in   32  rs1 value
//  alu_in_2     in   32  rs2 or immediate, muxed outside the block by alu_src
//  a7_val       in   32  register x17 value, used only for the halt check
//  is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write,
//  alu_src, write_enable, pc_to_reg, is_ecall   out 1 each  control signals
//  alu_op       out  4   decoded ALU operation
//  alu_result   out  32  ALU result
//  alu_bcond    out  1   branch condition is true
//  is_halted    out  1   registered, sticky halt flag
// BEHAVIOUR
//  Opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BR=1100011,
//   JAL=1101111, JALR=1100111, ECALL=1110011. Any other opcode drives all controls to 0.
//  Controls asserted per opcode (unlisted signals are 0):
//   R: write_enable. I-ALU: alu_src, write_enable.
//   LOAD: alu_src, mem_read, mem_to_reg, write_enable. STORE: alu_src, mem_write.
//   BR: branch. JAL: is_jal, pc_to_reg, write_enable.
//   JALR: is_jalr, alu_src, pc_to_reg, write_enable. ECALL: is_ecall.
//  alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 XOR, 6 OR, 7 AND,
//   8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
//  ALU-op decode uses funct3=instr[14:12] and f30=instr[30]:
//   R: 000 gives ADD, or SUB when f30=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//      101 gives SRL, or SRA when f30=1; 110 OR; 111 AND.
//   I-ALU: same table, but f30 is ignored except for funct3=101 (SRLI/SRAI),
//      so ADDI with imm[10]=1 stays ADD.
//   BR: funct3 000/001/100/101/110/111 map to BEQ/BNE/BLT/BGE/BLTU/BGEU;
//      funct3 010/011 map to BEQ.
//   LOAD, STORE, JALR, JAL, ECALL and unknown opcodes: ADD.
//  ALU is purely combinational.
//   Shift amount is alu_in_2[4:0]. SRA is arithmetic.
//   SLT/SLTU return 1 or 0 zero-extended to 32 bits.
//   Branch ops: alu_result = in1 - in2; alu_bcond = comparison result
//      (BLT/BGE signed, BLTU/BGEU unsigned).
//   Non-branch ops: alu_bcond = 0.
//   Adds and subtracts wrap modulo 2^32 with no overflow flag.
//  Halt:
//   On posedge clk, if is_ecall and a7_val==10, set is_halted to 1.
//   is_halted then holds 1 until reset. An ecall with any other a7 has no effect.
//  Reset: reset=0 clears is_halted asynchronously, including mid-run.
//   Combinational outputs do not depend on reset.
// STRUCTURE
//  Shared package rv32i_pkg holds the opcode localparams and the alu_op enum
//   (4-bit typedef) for reuse by datapath and testbench.
//  One sub-module, rv32i_alu, is natural: alu_op, in1, in2 -> result, bcond.
//  The control and ALU-op decoders stay inline as case statements.
// TESTING
//  R-type SUB: instr=0x40208033, in1=5, in2=7
//   -> alu_op=1, alu_result=0xFFFFFFFE, write_enable=1, alu_src=0.
//  ADDI with bit30 set: instr=0x40008093, in1=1, in2=0x400
//   -> alu_op=0 (ADD), alu_result=0x401, alu_src=1.
//  SRAI: instr=0x4010D093, in1=0x80000000, in2=1 -> alu_result=0xC0000000.
//  Branches with in1=0xFFFFFFFF, in2=1:
//   BLT -> alu_bcond=1; BLTU -> alu_bcond=0; BNE -> alu_bcond=1.
//  LW: mem_read=1, mem_to_reg=1, alu_src=1, alu_op=ADD.
//   SW: mem_write=1, write_enable=0.
//   JALR: is_jalr=1, pc_to_reg=1, alu_src=1.
//  Halt: ecall (0x00000073) with a7_val=9 -> is_halted stays 0.
//   With a7_val=10 -> is_halted=1 after the next posedge and stays 1 through
//   later instructions. Driving reset low clears it immediately, without waiting for clk.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants and the 4-bit ALU operation enum.
package rv32i_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;

  // a7 value that turns an ecall into a halt request
  localparam logic [31:0] HALT_A7 = 32'd10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU: arithmetic/logic result plus branch condition.
module rv32i_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e          alu_op,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  output logic [XLEN-1:0]  result,
  output logic             bcond
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] diff;
  logic            lt_s;
  logic            lt_u;

  assign shamt = in2[4:0];
  assign diff  = in1 - in2;
  assign lt_s  = $signed(in1) < $signed(in2);
  assign lt_u  = in1 < in2;

  // Result and branch-condition selection; branch ops report in1 - in2 as result
  always_comb begin
    result = diff;
    bcond  = 1'b0;
    case (alu_op)
      ALU_ADD:  result = in1 + in2;
      ALU_SUB:  result = diff;
      ALU_SLL:  result = in1 << shamt;
      ALU_SRL:  result = in1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(in1) >>> shamt);
      ALU_XOR:  result = in1 ^ in2;
      ALU_OR:   result = in1 | in2;
      ALU_AND:  result = in1 & in2;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_BEQ:  bcond  = (diff == '0);
      ALU_BNE:  bcond  = (diff != '0);
      ALU_BLT:  bcond  = lt_s;
      ALU_BGE:  bcond  = ~lt_s;
      ALU_BLTU: bcond  = lt_u;
      ALU_BGEU: bcond  = ~lt_u;
      default:  result = diff;
    endcase
  end

endmodule

// File: rtl/rv32i_ctrl_alu.sv
// Single-cycle RV32I control slice: main decoder, ALU-op decoder, ALU and sticky halt flag.
module rv32i_ctrl_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  alu_in_1,
  input  logic [XLEN-1:0]  alu_in_2,
  input  logic [31:0]      a7_val,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             alu_src,
  output logic             write_enable,
  output logic             pc_to_reg,
  output logic             is_ecall,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  alu_result,
  output logic             alu_bcond,
  output logic             is_halted
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f30;
  alu_op_e    op_sel;
  logic       halted_q;
  logic       halted_d;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f30          = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Main control decoder: one-hot style control set per opcode, all zero otherwise
  always_comb begin
    is_jal       = 1'b0;
    is_jalr      = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    write_enable = 1'b0;
    pc_to_reg    = 1'b0;
    is_ecall     = 1'b0;
    case (opcode)
      OPC_R:      write_enable = 1'b1;
      OPC_I_ALU: begin
        alu_src      = 1'b1;
        write_enable = 1'b1;
      end
      OPC_LOAD: begin
        alu_src      = 1'b1;
        mem_read     = 1'b1;
        mem_to_reg   = 1'b1;
        write_enable = 1'b1;
      end
      OPC_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OPC_BRANCH: branch = 1'b1;
      OPC_JAL: begin
        is_jal       = 1'b1;
        pc_to_reg    = 1'b1;
        write_enable = 1'b1;
      end
      OPC_JALR: begin
        is_jalr      = 1'b1;
        alu_src      = 1'b1;
        pc_to_reg    = 1'b1;
        write_enable = 1'b1;
      end
      OPC_ECALL:  is_ecall = 1'b1;
      default: ;
    endcase
  end

  // ALU-op decoder; for I-type, bit 30 is immediate data except on shifts-right
  always_comb begin
    op_sel = ALU_ADD;
    if (opcode == OPC_R || opcode == OPC_I_ALU) begin
      case (funct3)
        3'b000:  op_sel = (opcode == OPC_R && f30) ? ALU_SUB : ALU_ADD;
        3'b001:  op_sel = ALU_SLL;
        3'b010:  op_sel = ALU_SLT;
        3'b011:  op_sel = ALU_SLTU;
        3'b100:  op_sel = ALU_XOR;
        3'b101:  op_sel = f30 ? ALU_SRA : ALU_SRL;
        3'b110:  op_sel = ALU_OR;
        default: op_sel = ALU_AND;
      endcase
    end else if (opcode == OPC_BRANCH) begin
      case (funct3)
        3'b001:  op_sel = ALU_BNE;
        3'b100:  op_sel = ALU_BLT;
        3'b101:  op_sel = ALU_BGE;
        3'b110:  op_sel = ALU_BLTU;
        3'b111:  op_sel = ALU_BGEU;
        default: op_sel = ALU_BEQ;
      endcase
    end
  end

  assign alu_op = op_sel;

  rv32i_alu #(.XLEN(XLEN)) u_alu (
    .alu_op (op_sel),
    .in1    (alu_in_1),
    .in2    (alu_in_2),
    .result (alu_result),
    .bcond  (alu_bcond)
  );

  // Halt request is sticky: once set only reset clears it
  always_comb begin
    halted_d = halted_q | (is_ecall & (a7_val == HALT_A7));
  end

  // Halt flag register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign is_halted = halted_q;

endmodule

// File: tb/tb_rv32i_ctrl_alu.sv
// Self-checking bench for rv32i_ctrl_alu: directed cases, randomized decode/ALU
// against a behavioural model, and halt-flag sequencing.
module tb_rv32i_ctrl_alu;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic [31:0] a7_val;
  logic        is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write;
  logic        alu_src, write_enable, pc_to_reg, is_ecall;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_bcond;
  logic        is_halted;

  int checks   = 0;
  int failures = 0;

  // {is_jal,is_jalr,branch,mem_read,mem_to_reg,mem_write,alu_src,write_enable,pc_to_reg,is_ecall}
  logic [9:0] dut_ctl;
  assign dut_ctl = {is_jal, is_jalr, branch, mem_read, mem_to_reg, mem_write,
                    alu_src, write_enable, pc_to_reg, is_ecall};

  rv32i_ctrl_alu #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .alu_in_1     (alu_in_1),
    .alu_in_2     (alu_in_2),
    .a7_val       (a7_val),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .write_enable (write_enable),
    .pc_to_reg    (pc_to_reg),
    .is_ecall     (is_ecall),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_bcond    (alu_bcond),
    .is_halted    (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: expected controls, op, result and branch condition
  task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       output logic [9:0] ctl, output logic [3:0] op,
                       output logic [31:0] res, output logic bc);
    logic [6:0] opc;
    logic [2:0] f3;
    int unsigned sh;
    opc = ins[6:0];
    f3  = ins[14:12];
    sh  = int'(b[4:0]);
    ctl = 10'b0;
    op  = 4'd0;
    case (opc)
      7'b0110011: ctl = 10'b0000000100;
      7'b0010011: ctl = 10'b0000001100;
      7'b0000011: ctl = 10'b0001101100;
      7'b0100011: ctl = 10'b0000011000;
      7'b1100011: ctl = 10'b0010000000;
      7'b1101111: ctl = 10'b1000000110;
      7'b1100111: ctl = 10'b0100001110;
      7'b1110011: ctl = 10'b0000000001;
      default:    ctl = 10'b0;
    endcase
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      case (f3)
        3'd0: op = (opc == 7'b0110011 && ins[30]) ? 4'd1 : 4'd0;
        3'd1: op = 4'd2;
        3'd2: op = 4'd8;
        3'd3: op = 4'd9;
        3'd4: op = 4'd5;
        3'd5: op = ins[30] ? 4'd4 : 4'd3;
        3'd6: op = 4'd6;
        default: op = 4'd7;
      endcase
    end else if (opc == 7'b1100011) begin
      case (f3)
        3'd1: op = 4'd11;
        3'd4: op = 4'd12;
        3'd5: op = 4'd13;
        3'd6: op = 4'd14;
        3'd7: op = 4'd15;
        default: op = 4'd10;
      endcase
    end
    bc = 1'b0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a << sh;
      4'd3: res = a >> sh;
      4'd4: res = $unsigned($signed(a) >>> sh);
      4'd5: res = a ^ b;
      4'd6: res = a | b;
      4'd7: res = a & b;
      4'd8: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        res = a - b;
        case (op)
          4'd10: bc = (a == b);
          4'd11: bc = (a != b);
          4'd12: bc = ($signed(a) < $signed(b));
          4'd13: bc = ($signed(a) >= $signed(b));
          4'd14: bc = (a < b);
          default: bc = (a >= b);
        endcase
      end
    endcase
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr    = ins;
    alu_in_1 = a;
    alu_in_2 = b;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a7_val = 32'd0;
    apply(32'h0000_0000, 32'd3, 32'd4);
    checks++;
    if (is_halted !== 1'b0) begin
      failures++; $display("FAIL reset_halted got=%b want=0", is_halted);
    end
    checks++;
    if (dut_ctl !== 10'b0) begin
      failures++; $display("FAIL reset_unknown_ctl got=%b want=0", dut_ctl);
    end
    checks++;
    if (alu_op !== 4'd0 || alu_result !== 32'd7) begin
      failures++; $display("FAIL reset_unknown_alu op=%0d res=%h want op=0 res=00000007", alu_op, alu_result);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    apply(32'h4020_8033, 32'd5, 32'd7);
    checks++;
    if (alu_op !== 4'd1 || alu_result !== 32'hFFFF_FFFE || write_enable !== 1'b1 || alu_src !== 1'b0) begin
      failures++; $display("FAIL r_sub op=%0d res=%h we=%b src=%b want 1 fffffffe 1 0", alu_op, alu_result, write_enable, alu_src);
    end
    apply(32'h4000_8093, 32'd1, 32'h400);
    checks++;
    if (alu_op !== 4'd0 || alu_result !== 32'h401 || alu_src !== 1'b1) begin
      failures++; $display("FAIL addi_b30 op=%0d res=%h src=%b want 0 00000401 1", alu_op, alu_result, alu_src);
    end
    apply(32'h4010_D093, 32'h8000_0000, 32'd1);
    checks++;
    if (alu_op !== 4'd4 || alu_result !== 32'hC000_0000) begin
      failures++; $display("FAIL srai op=%0d res=%h want 4 c0000000", alu_op, alu_result);
    end
    apply(32'h0000_4063, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (alu_bcond !== 1'b1 || branch !== 1'b1) begin
      failures++; $display("FAIL blt bcond=%b branch=%b want 1 1", alu_bcond, branch);
    end
    apply(32'h0000_6063, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (alu_bcond !== 1'b0) begin
      failures++; $display("FAIL bltu bcond=%b want 0", alu_bcond);
    end
    apply(32'h0000_1063, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (alu_bcond !== 1'b1) begin
      failures++; $display("FAIL bne bcond=%b want 1", alu_bcond);
    end
    apply(32'h0000_2003, 32'd8, 32'd4);
    checks++;
    if (mem_read !== 1'b1 || mem_to_reg !== 1'b1 || alu_src !== 1'b1 || alu_op !== 4'd0) begin
      failures++; $display("FAIL lw rd=%b m2r=%b src=%b op=%0d want 1 1 1 0", mem_read, mem_to_reg, alu_src, alu_op);
    end
    apply(32'h0000_2023, 32'd8, 32'd4);
    checks++;
    if (mem_write !== 1'b1 || write_enable !== 1'b0) begin
      failures++; $display("FAIL sw mw=%b we=%b want 1 0", mem_write, write_enable);
    end
    apply(32'h0000_0067, 32'd8, 32'd4);
    checks++;
    if (is_jalr !== 1'b1 || pc_to_reg !== 1'b1 || alu_src !== 1'b1) begin
      failures++; $display("FAIL jalr jalr=%b p2r=%b src=%b want 1 1 1", is_jalr, pc_to_reg, alu_src);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [12];
    logic [31:0] ins, a, b, eres;
    logic [9:0]  ectl;
    logic [3:0]  eop;
    logic        ebc;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b1110011, 7'b0000000, 7'b0110111, 7'b0010111, 7'b1111111};
    a7_val = 32'd0;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 11)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {a[31:8], 8'($urandom)};
        default: ;
      endcase
      apply(ins, a, b);
      model(ins, a, b, ectl, eop, eres, ebc);
      checks++;
      if (dut_ctl !== ectl) begin
        failures++; $display("FAIL rnd_ctl instr=%h got=%b want=%b", ins, dut_ctl, ectl);
      end
      checks++;
      if (alu_op !== eop) begin
        failures++; $display("FAIL rnd_op instr=%h got=%0d want=%0d", ins, alu_op, eop);
      end
      checks++;
      if (alu_result !== eres) begin
        failures++; $display("FAIL rnd_res instr=%h a=%h b=%h got=%h want=%h", ins, a, b, alu_result, eres);
      end
      checks++;
      if (alu_bcond !== ebc) begin
        failures++; $display("FAIL rnd_bcond instr=%h a=%h b=%h got=%b want=%b", ins, a, b, alu_bcond, ebc);
      end
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    instr = 32'h0000_0073;
    a7_val = 32'd9;
    @(posedge clk); #1;
    checks++;
    if (is_halted !== 1'b0) begin
      failures++; $display("FAIL halt_a7_9 got=%b want=0", is_halted);
    end
    @(negedge clk);
    a7_val = 32'd10;
    #1;
    checks++;
    if (is_halted !== 1'b0) begin
      failures++; $display("FAIL halt_before_edge got=%b want=0", is_halted);
    end
    @(posedge clk); #1;
    checks++;
    if (is_halted !== 1'b1) begin
      failures++; $display("FAIL halt_set got=%b want=1", is_halted);
    end
    @(negedge clk);
    instr = 32'h4020_8033;
    a7_val = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (is_halted !== 1'b1) begin
        failures++; $display("FAIL halt_sticky cycle=%0d got=%b want=1", i, is_halted);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (is_halted !== 1'b0) begin
      failures++; $display("FAIL halt_async_clear got=%b want=0", is_halted);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (is_halted !== 1'b0) begin
      failures++; $display("FAIL halt_after_reset got=%b want=0", is_halted);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
